// File: rtl/comp_distance.sv
// comp_distance
//
// Fitness helper for the genetic route optimiser. Computes the total
// Manhattan length of a closed tour through N_POINTS points packed into one
// chromosome word. The whole sum is combinational (per-segment
// compare-and-subtract, then an adder tree) and the result is registered,
// so there is one clock of latency and a new result every cycle.
//
// Gene i occupies in[GENE_W*i +: GENE_W]; the upper COORD_W bits are x and
// the lower COORD_W bits are y, both unsigned. The tour is closed: the last
// gene connects back to gene 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in         chromosome, N_POINTS genes of 2*COORD_W bits each
//   out        registered total tour distance, zero-extended to OUT_W bits
//   out_valid  high when out holds a result computed from a sampled in
//
// Flow control: there is no handshake and no ready. out_valid is a
// valid-only qualifier that rises at the first clock edge after reset is
// released and stays high until the next reset; every cycle is an
// independent computation and the consumer cannot stall it.
//
// The adder tree has four levels, so it serves up to 16 points; unused
// leaves are tied to zero.

module comp_distance #(
  parameter int N_POINTS = 15,
  parameter int COORD_W  = 5,
  parameter int OUT_W    = 13
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_POINTS*2*COORD_W-1:0]   in,
  output logic [OUT_W-1:0]                out,
  output logic                            out_valid
);

  localparam int GENE_W = 2 * COORD_W;
  // |dx| + |dy| needs one bit more than a coordinate; keep a spare bit.
  localparam int SEG_W  = COORD_W + 2;
  localparam int LEAVES = 16;

  // Unsigned absolute difference as larger minus smaller.
  function automatic logic [COORD_W-1:0] abs_diff(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  logic [COORD_W-1:0] x [N_POINTS];
  logic [COORD_W-1:0] y [N_POINTS];
  logic [SEG_W-1:0]   seg [N_POINTS];

  logic [OUT_W-1:0]   lvl0 [LEAVES];
  logic [OUT_W-1:0]   lvl1 [LEAVES/2];
  logic [OUT_W-1:0]   lvl2 [LEAVES/4];
  logic [OUT_W-1:0]   lvl3 [LEAVES/8];
  logic [OUT_W-1:0]   total;

  logic [OUT_W-1:0]   out_d;
  logic [OUT_W-1:0]   out_q;
  logic               out_valid_d;
  logic               out_valid_q;

  // Unpack coordinates.
  always_comb begin
    for (int i = 0; i < N_POINTS; i++) begin
      x[i] = in[GENE_W*i+COORD_W +: COORD_W];
      y[i] = in[GENE_W*i         +: COORD_W];
    end
  end

  // Segment lengths; the last point wraps to point 0 to close the tour.
  always_comb begin
    for (int i = 0; i < N_POINTS; i++) begin
      seg[i] = SEG_W'(abs_diff(x[i], x[(i + 1) % N_POINTS]))
             + SEG_W'(abs_diff(y[i], y[(i + 1) % N_POINTS]));
    end
  end

  // Leaves of the adder tree, zero-extended to the output width.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      lvl0[i] = '0;
    end
    for (int i = 0; i < N_POINTS; i++) begin
      lvl0[i] = OUT_W'(seg[i]);
    end
  end

  // Balanced pairwise reduction, one stage per level.
  always_comb begin
    for (int i = 0; i < LEAVES/2; i++) begin
      lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
    end
  end

  always_comb begin
    for (int i = 0; i < LEAVES/4; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
  end

  always_comb begin
    for (int i = 0; i < LEAVES/8; i++) begin
      lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
    end
  end

  // Maximum total is 62 * 15 = 930, well inside OUT_W bits: no saturation.
  assign total = lvl3[0] + lvl3[1];

  always_comb begin
    out_d       = total;
    out_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_comp_distance.sv
// tb_comp_distance
//
// Bench for comp_distance. Expected totals come from a behavioural model
// that walks the tour with plain integer arithmetic. Inputs are driven 1 ns
// after the rising edge and outputs are sampled there as well.

module tb_comp_distance;

  localparam int N  = 15;
  localparam int CW = 5;
  localparam int OW = 13;
  localparam int IW = N * 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_v = '0;
  logic [OW-1:0] out_v;
  logic          out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] exp_q[$];
  logic          expv_q[$];

  comp_distance dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_v),
    .out       (out_v),
    .out_valid (out_valid)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: closed tour, Manhattan length, plain integer math.
  function automatic logic [OW-1:0] ref_total(input logic [IW-1:0] v);
    int total;
    int xa, ya, xb, yb, dx, dy, j;
    total = 0;
    for (int i = 0; i < N; i++) begin
      j  = (i + 1) % N;
      xa = int'(v[10*i+5 +: 5]);
      ya = int'(v[10*i   +: 5]);
      xb = int'(v[10*j+5 +: 5]);
      yb = int'(v[10*j   +: 5]);
      dx = xa - xb;
      dy = ya - yb;
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      total = total + dx + dy;
    end
    return OW'(total);
  endfunction

  function automatic logic [IW-1:0] set_gene(input logic [IW-1:0] v,
                                             input int i, input int gx,
                                             input int gy);
    logic [IW-1:0] r;
    r = v;
    r[10*i +: 10] = {5'(gx), 5'(gy)};
    return r;
  endfunction

  function automatic logic [IW-1:0] pattern(input int k);
    logic [IW-1:0] v;
    v = '0;
    case (k)
      0: v = IW'(3);
      1: for (int i = 0; i < N; i++) v = set_gene(v, i, 0, 6);
      2: for (int i = 0; i < N; i += 2) v = set_gene(v, i, 31, 31);
      default: v = set_gene(v, 7, 10, 0);
    endcase
    return v;
  endfunction

  function automatic logic [IW-1:0] rand_in();
    logic [IW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[10*i +: 10] = 10'($urandom);
    return v;
  endfunction

  // Driver: one clock, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare of the next queued expectation.
  task automatic sb_cycle(input string name);
    logic [OW-1:0] e;
    logic          ev;
    tick();
    e  = exp_q.pop_front();
    ev = expv_q.pop_front();
    n_checks++;
    if (out_v !== e) begin
      n_fail++;
      $display("FAIL %s out: got %0d expected %0d", name, out_v, e);
    end
    n_checks++;
    if (out_valid !== ev) begin
      n_fail++;
      $display("FAIL %s out_valid: got %0b expected %0b", name, out_valid, ev);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_v  = rand_in();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (out_v !== '0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got out=%0d valid=%0b expected out=0 valid=0",
                 out_v, out_valid);
      end
    end
    rst_n = 1'b1;
    in_v  = pattern(0);
    tick();
    n_checks++;
    if (out_v !== 13'd6 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got out=%0d valid=%0b expected out=6 valid=1",
               out_v, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [OW-1:0] want [3];
    want[0] = 13'd0;
    want[1] = 13'd868;
    want[2] = 13'd20;
    for (int k = 1; k <= 3; k++) begin
      in_v = pattern(k);
      tick();
      n_checks++;
      if (out_v !== want[k-1]) begin
        n_fail++;
        $display("FAIL directed_%0d: got %0d expected %0d", k, out_v, want[k-1]);
      end
    end
  endtask

  task automatic test_latency();
    in_v = pattern(2);
    tick();
    in_v = pattern(3);
    #2;
    n_checks++;
    if (out_v !== 13'd868) begin
      n_fail++;
      $display("FAIL latency_hold: got %0d expected 868", out_v);
    end
    tick();
    n_checks++;
    if (out_v !== 13'd20) begin
      n_fail++;
      $display("FAIL latency_capture: got %0d expected 20", out_v);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      rst_n = (c == 5) ? 1'b0 : 1'b1;
      in_v  = pattern(c % 4);
      exp_q.push_back(rst_n ? ref_total(in_v) : '0);
      expv_q.push_back(rst_n);
      sb_cycle("back_to_back");
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      rst_n = ($urandom_range(0, 9) != 0);
      in_v  = rand_in();
      exp_q.push_back(rst_n ? ref_total(in_v) : '0);
      expv_q.push_back(rst_n);
      sb_cycle("random");
    end
    rst_n = 1'b1;
    // Extreme corners: maximal and minimal tours.
    for (int c = 0; c < 2; c++) begin
      in_v = '0;
      for (int i = 0; i < N; i++) begin
        if (c == 0) in_v = set_gene(in_v, i, (i % 2) ? 0 : 31, (i % 2) ? 31 : 0);
        else        in_v = set_gene(in_v, i, 31, 31);
      end
      exp_q.push_back(ref_total(in_v));
      expv_q.push_back(1'b1);
      sb_cycle("corner");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
